// File: rtl/mtr_drv.sv
// mtr_drv: dual-channel H-bridge PWM drive stage.
// Converts signed left/right wheel speeds into complementary PWM pairs with
// dead time and a per-period slew limit. Both channels share one free-running
// 2048-cycle period counter, so their duty updates happen on the same cycle.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   lft_spd   signed left speed (-1024..+1023), sampled when cnt == 2047
//   rght_spd  signed right speed, same format
//   lftPWM1   left high-side drive (forward)
//   lftPWM2   left low-side drive (complement)
//   rghtPWM1  right high-side drive (forward)
//   rghtPWM2  right low-side drive (complement)
//   prd_strt  one-cycle pulse on the first cycle of each PWM period
module mtr_drv #(
   parameter int unsigned DEAD_TIME = 32,
   parameter int unsigned SLEW_STEP = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [10:0] lft_spd,
   input  logic signed [10:0] rght_spd,
   output logic               lftPWM1,
   output logic               lftPWM2,
   output logic               rghtPWM1,
   output logic               rghtPWM2,
   output logic               prd_strt
);

   localparam logic        [11:0] DT12 = 12'(DEAD_TIME);
   localparam logic signed [11:0] SS12 = 12'(SLEW_STEP);
   localparam logic        [10:0] SS11 = 11'(SLEW_STEP);

   logic [10:0] cnt_q, cnt_d;
   logic [10:0] lft_duty_q, lft_duty_d;
   logic [10:0] rght_duty_q, rght_duty_d;
   logic        lft_pwm1_q, lft_pwm1_d;
   logic        lft_pwm2_q, lft_pwm2_d;
   logic        rght_pwm1_q, rght_pwm1_d;
   logic        rght_pwm2_q, rght_pwm2_d;
   logic        prd_strt_q, prd_strt_d;

   // Signed speed to unsigned duty target: adding 1024 is an MSB flip.
   function automatic logic [10:0] spd_to_tgt(input logic [10:0] spd);
      spd_to_tgt = {~spd[10], spd[9:0]};
   endfunction

   // Move duty toward target by at most SLEW_STEP. The 12-bit signed
   // difference cannot overflow, and a full step is only taken when the
   // target is further away than the step, so duty never leaves 0..2047.
   function automatic logic [10:0] slew(input logic [10:0] duty,
                                        input logic [10:0] tgt);
      logic signed [11:0] diff;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, duty});
      if (diff > SS12)
         slew = duty + SS11;
      else if (diff < -SS12)
         slew = duty - SS11;
      else
         slew = tgt;
   endfunction

   function automatic logic pwm_hi(input logic [10:0] cnt, input logic [10:0] duty);
      pwm_hi = ({1'b0, cnt} >= DT12) && (cnt < duty);
   endfunction

   // 12-bit sum: duty + DEAD_TIME past 2047 keeps the low side off all period.
   function automatic logic pwm_lo(input logic [10:0] cnt, input logic [10:0] duty);
      pwm_lo = ({1'b0, cnt} >= ({1'b0, duty} + DT12));
   endfunction

   always_comb begin
      cnt_d       = cnt_q + 11'd1;
      lft_duty_d  = lft_duty_q;
      rght_duty_d = rght_duty_q;
      if (cnt_q == 11'd2047) begin
         lft_duty_d  = slew(lft_duty_q, spd_to_tgt(lft_spd));
         rght_duty_d = slew(rght_duty_q, spd_to_tgt(rght_spd));
      end
      lft_pwm1_d  = pwm_hi(cnt_q, lft_duty_q);
      lft_pwm2_d  = pwm_lo(cnt_q, lft_duty_q);
      rght_pwm1_d = pwm_hi(cnt_q, rght_duty_q);
      rght_pwm2_d = pwm_lo(cnt_q, rght_duty_q);
      prd_strt_d  = (cnt_q == 11'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= 11'd0;
         lft_duty_q  <= 11'd1024;
         rght_duty_q <= 11'd1024;
         lft_pwm1_q  <= 1'b0;
         lft_pwm2_q  <= 1'b0;
         rght_pwm1_q <= 1'b0;
         rght_pwm2_q <= 1'b0;
         prd_strt_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         lft_duty_q  <= lft_duty_d;
         rght_duty_q <= rght_duty_d;
         lft_pwm1_q  <= lft_pwm1_d;
         lft_pwm2_q  <= lft_pwm2_d;
         rght_pwm1_q <= rght_pwm1_d;
         rght_pwm2_q <= rght_pwm2_d;
         prd_strt_q  <= prd_strt_d;
      end
   end

   assign lftPWM1  = lft_pwm1_q;
   assign lftPWM2  = lft_pwm2_q;
   assign rghtPWM1 = rght_pwm1_q;
   assign rghtPWM2 = rght_pwm2_q;
   assign prd_strt = prd_strt_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Testbench for mtr_drv: cycle-by-cycle comparison against a behavioural
// model, plus per-period high-time counts and prd_strt spacing.
module tb_mtr_drv;

   localparam int DT = 32;
   localparam int SS = 200;

   logic               clk;
   logic               rst_n;
   logic signed [10:0] lft_spd;
   logic signed [10:0] rght_spd;
   logic               lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt;

   mtr_drv #(.DEAD_TIME(DT), .SLEW_STEP(SS)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .lft_spd  (lft_spd),
      .rght_spd (rght_spd),
      .lftPWM1  (lftPWM1),
      .lftPWM2  (lftPWM2),
      .rghtPWM1 (rghtPWM1),
      .rghtPWM2 (rghtPWM2),
      .prd_strt (prd_strt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   int m_cnt = 0;
   int m_dl  = 1024;
   int m_dr  = 1024;

   int lft_goal = 0, rght_goal = 0;
   bit junk_en = 1'b0;

   // period statistics
   bit full = 1'b0;
   int o_l1, o_l2, o_r1, o_r2;
   int last_l1 = -1, last_l2 = -1, last_r1 = -1, last_r2 = -1;
   int cyc = 0, last_ps = 0;
   bit have_ps = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s obs=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int slew_m(input int d, input int t);
      int diff;
      diff = t - d;
      if (diff <= SS && diff >= -SS) return t;
      if (diff > 0) return d + SS;
      return d - SS;
   endfunction

   function automatic int hi_cnt(input int d);
      return (d > DT) ? d - DT : 0;
   endfunction

   function automatic int lo_cnt(input int d);
      return (d + DT <= 2047) ? 2048 - (d + DT) : 0;
   endfunction

   task automatic drive();
      if (junk_en && m_cnt != 2047 && $urandom_range(0, 7) == 0) begin
         lft_spd  = 11'($urandom_range(0, 2047));
         rght_spd = 11'($urandom_range(0, 2047));
      end else begin
         lft_spd  = 11'(lft_goal);
         rght_spd = 11'(rght_goal);
      end
   endtask

   task automatic step();
      int c, dl, dr, sl, sr;
      int e_l1, e_l2, e_r1, e_r2, e_ps;
      bit in_rst;
      drive();
      c = m_cnt; dl = m_dl; dr = m_dr;
      sl = int'(lft_spd); sr = int'(rght_spd);
      in_rst = !rst_n;
      @(posedge clk);
      #1;
      cyc++;
      if (in_rst) begin
         e_l1 = 0; e_l2 = 0; e_r1 = 0; e_r2 = 0; e_ps = 0;
         m_cnt = 0; m_dl = 1024; m_dr = 1024;
         full = 1'b0; have_ps = 1'b0;
      end else begin
         e_l1 = int'(c >= DT && c < dl);
         e_l2 = int'(c >= dl + DT);
         e_r1 = int'(c >= DT && c < dr);
         e_r2 = int'(c >= dr + DT);
         e_ps = int'(c == 0);
         if (c == 2047) begin
            m_dl = slew_m(dl, sl + 1024);
            m_dr = slew_m(dr, sr + 1024);
         end
         m_cnt = (c + 1) % 2048;
      end
      chk("lftPWM1", int'(lftPWM1), e_l1);
      chk("lftPWM2", int'(lftPWM2), e_l2);
      chk("rghtPWM1", int'(rghtPWM1), e_r1);
      chk("rghtPWM2", int'(rghtPWM2), e_r2);
      chk("prd_strt", int'(prd_strt), e_ps);
      if (lftPWM1 && lftPWM2) chk("lft_overlap", 1, 0);
      if (rghtPWM1 && rghtPWM2) chk("rght_overlap", 1, 0);
      if (prd_strt) begin
         if (have_ps) chk("ps_gap", cyc - last_ps, 2048);
         have_ps = 1'b1;
         last_ps = cyc;
      end
      if (!in_rst) begin
         if (c == 0) begin
            full = 1'b1;
            o_l1 = 0; o_l2 = 0; o_r1 = 0; o_r2 = 0;
         end
         o_l1 += int'(lftPWM1); o_l2 += int'(lftPWM2);
         o_r1 += int'(rghtPWM1); o_r2 += int'(rghtPWM2);
         if (c == 2047 && full) begin
            chk("l1_per", o_l1, hi_cnt(dl));
            chk("l2_per", o_l2, lo_cnt(dl));
            chk("r1_per", o_r1, hi_cnt(dr));
            chk("r2_per", o_r2, lo_cnt(dr));
            last_l1 = o_l1; last_l2 = o_l2; last_r1 = o_r1; last_r2 = o_r2;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to(input int c);
      for (int i = 0; i < 4096 && m_cnt != c; i++) step();
      chk("run_to", m_cnt, c);
   endtask

   initial begin
      rst_n = 1'b0;
      lft_spd = '0;
      rght_spd = '0;
      run(3);
      rst_n = 1'b1;

      // zero speed: 50% duty, symmetric dead time
      run(3 * 2048 + 1);
      chk("spd0_l1", last_l1, 992);
      chk("spd0_l2", last_l2, 992);
      chk("spd0_r1", last_r1, 992);
      chk("spd0_r2", last_r2, 992);

      // full forward step on left, right idle
      lft_goal = 1023;
      run(8 * 2048);
      chk("fwd_l1", last_l1, 2015);
      chk("fwd_l2", last_l2, 0);
      chk("fwd_r1", last_r1, 992);
      chk("fwd_r2", last_r2, 992);

      // full reverse
      lft_goal = -1024;
      run(12 * 2048);
      chk("rev_l1", last_l1, 0);
      chk("rev_l2", last_l2, 2016);

      // mid-period glitch on right speed is ignored
      run_to(500);
      rght_goal = 700;
      run_to(1500);
      rght_goal = 0;
      run(2 * 2048);
      chk("glitch_r1", last_r1, 992);
      chk("glitch_r2", last_r2, 992);

      // random targets with junk between period ends
      junk_en = 1'b1;
      for (int p = 0; p < 3; p++) begin
         run_to(0);
         lft_goal  = int'($urandom_range(0, 2047)) - 1024;
         rght_goal = int'($urandom_range(0, 2047)) - 1024;
         run(2048);
      end
      junk_en = 1'b0;

      // reset mid-period with duty away from 50%
      lft_goal = 600;
      run(2 * 2048);
      run_to(700);
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      lft_goal = 0; rght_goal = 0;
      run(2048 + 2);
      chk("rst_l1", last_l1, 992);
      chk("rst_l2", last_l2, 992);
      chk("rst_r1", last_r1, 992);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
